// File: rtl/counter_driver.sv
// Command-driven initiator for the 4-mode up/down/load counter: primes the counter
// with a seed, runs it CMD_LEN cycles, and checks every returned sample against a shadow model.
module counter_driver #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_MODO,
    input  logic [3:0]       CMD_SEED,
    input  logic [3:0]       CMD_D,
    input  logic [LEN_W-1:0] CMD_LEN,
    output logic             CNT_RESET,
    output logic             CNT_ENABLE,
    output logic [1:0]       CNT_MODO,
    output logic [3:0]       CNT_D,
    input  logic [3:0]       CNT_Q,
    input  logic             CNT_RCO,
    input  logic             CNT_LOAD,
    output logic             BUSY,
    output logic             DONE,
    output logic [3:0]       RESULT_Q,
    output logic [LEN_W-1:0] RCO_CNT,
    output logic             ERR,
    output logic [LEN_W-1:0] ERR_STEP
);

    typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, FIN} state_t;

    state_t           state;
    logic [1:0]       modo_r;
    logic [3:0]       seed_r;
    logic [3:0]       d_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] idx;

    logic [3:0]       exp_q;
    logic             exp_rco;
    logic             exp_load;

    logic [4:0]       step_sum;
    logic             mismatch;
    logic             sampling;

    // {RCO,Q} result of applying the latched mode to the current shadow value
    always_comb begin
        step_sum = '0;
        unique case (modo_r)
            2'b00:   step_sum = {1'b0, exp_q} + 5'd3;
            2'b01:   step_sum = {1'b0, exp_q} - 5'd1;
            2'b10:   step_sum = {1'b0, exp_q} + 5'd1;
            default: step_sum = {1'b0, d_r};
        endcase
    end

    always_comb begin
        mismatch = (CNT_Q != exp_q) || (CNT_RCO != exp_rco) || (CNT_LOAD != exp_load);
        sampling = (state == RUN) || (state == DRAIN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            CMD_READY  <= 1'b0;
            CNT_RESET  <= 1'b1;
            CNT_ENABLE <= 1'b0;
            CNT_MODO   <= '0;
            CNT_D      <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RESULT_Q   <= '0;
            RCO_CNT    <= '0;
            ERR        <= 1'b0;
            ERR_STEP   <= '0;
            modo_r     <= '0;
            seed_r     <= '0;
            d_r        <= '0;
            len_r      <= '0;
            idx        <= '0;
            exp_q      <= '0;
            exp_rco    <= 1'b0;
            exp_load   <= 1'b0;
        end else begin
            CNT_RESET <= 1'b0;
            DONE      <= 1'b0;

            // Counter output lags the issued command by one edge, so samples are
            // taken on every closing edge of RUN and DRAIN.
            if (sampling) begin
                RESULT_Q <= CNT_Q;
                if ((idx != '0) && CNT_RCO && (RCO_CNT != '1))
                    RCO_CNT <= RCO_CNT + 1'b1;
                if (mismatch && !ERR) begin
                    ERR      <= 1'b1;
                    ERR_STEP <= idx;
                end
                idx <= idx + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        modo_r     <= CMD_MODO;
                        seed_r     <= CMD_SEED;
                        d_r        <= CMD_D;
                        len_r      <= CMD_LEN;
                        ERR        <= 1'b0;
                        ERR_STEP   <= '0;
                        RCO_CNT    <= '0;
                        idx        <= '0;
                        CMD_READY  <= 1'b0;
                        BUSY       <= 1'b1;
                        CNT_ENABLE <= 1'b1;
                        CNT_MODO   <= 2'b11;
                        CNT_D      <= CMD_SEED;
                        state      <= PRIME;
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end
                PRIME: begin
                    exp_q    <= seed_r;
                    exp_rco  <= 1'b0;
                    exp_load <= 1'b1;
                    if (len_r == '0) begin
                        CNT_ENABLE <= 1'b0;
                        CNT_MODO   <= '0;
                        CNT_D      <= '0;
                        state      <= DRAIN;
                    end else begin
                        CNT_MODO <= modo_r;
                        CNT_D    <= d_r;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    exp_q    <= step_sum[3:0];
                    exp_rco  <= step_sum[4];
                    exp_load <= (modo_r == 2'b11);
                    if (idx == len_r - 1'b1) begin
                        CNT_ENABLE <= 1'b0;
                        CNT_MODO   <= '0;
                        CNT_D      <= '0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    DONE  <= 1'b1;
                    state <= FIN;
                end
                FIN: begin
                    BUSY      <= 1'b0;
                    CMD_READY <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
